// File: rtl/moving_avg_filter.sv
// rtl/moving_avg_filter.sv - streaming mean of the last 2^LOG2_N samples, sliding or block mode
module moving_avg_filter #(
    parameter int DW     = 16,
    parameter int LOG2_N = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] x,
    input  logic          mode,
    input  logic          flush,
    output logic [DW-1:0] y,
    output logic          out_valid,
    output logic          win_full
);

    localparam int N  = 1 << LOG2_N;
    localparam int SW = DW + LOG2_N;
    localparam int CW = LOG2_N + 1;

    typedef enum logic {
        S_FILL   = 1'b0,
        S_STEADY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [SW-1:0]       r_sum;
    logic [SW-1:0]       w_sum_next;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_next;
    logic [LOG2_N-1:0]   r_wr_ptr;
    logic [LOG2_N-1:0]   w_wr_ptr_next;
    logic                r_mode;
    logic [DW-1:0]       r_buf [N];
    logic [DW-1:0]       r_y;
    logic                r_out_valid;

    logic                w_clear;
    logic                w_accept;
    logic [DW-1:0]       w_old;
    logic [SW-1:0]       w_sum_add;
    logic [SW-1:0]       w_sum_slide;
    logic [CW-1:0]       w_cnt_inc;
    logic                w_pulse;
    logic [DW-1:0]       w_y_next;

    // A mode change is treated exactly like a flush, including dropping the offered sample.
    assign w_clear     = flush | (mode != r_mode);
    assign w_accept    = in_valid & ~w_clear;
    assign w_old       = r_buf[r_wr_ptr];
    assign w_sum_add   = r_sum + SW'(x);
    assign w_sum_slide = w_sum_add - SW'(w_old);
    assign w_cnt_inc   = r_cnt + CW'(1);

    always_comb begin
        w_state_next  = r_state;
        w_sum_next    = r_sum;
        w_cnt_next    = r_cnt;
        w_wr_ptr_next = r_wr_ptr;
        w_pulse       = 1'b0;
        w_y_next      = r_y;
        if (w_clear) begin
            w_state_next  = S_FILL;
            w_sum_next    = '0;
            w_cnt_next    = '0;
            w_wr_ptr_next = '0;
        end else if (w_accept) begin
            w_wr_ptr_next = r_wr_ptr + LOG2_N'(1);
            case (r_state)
                S_FILL: begin
                    if (w_cnt_inc == CW'(N)) begin
                        w_pulse  = 1'b1;
                        w_y_next = w_sum_add[SW-1:LOG2_N];
                        if (mode) begin
                            // Block mode: restart the accumulation for the next N samples.
                            w_sum_next = '0;
                            w_cnt_next = '0;
                        end else begin
                            w_sum_next   = w_sum_add;
                            w_cnt_next   = w_cnt_inc;
                            w_state_next = S_STEADY;
                        end
                    end else begin
                        w_sum_next = w_sum_add;
                        w_cnt_next = w_cnt_inc;
                    end
                end
                S_STEADY: begin
                    w_pulse    = 1'b1;
                    w_sum_next = w_sum_slide;
                    w_y_next   = w_sum_slide[SW-1:LOG2_N];
                end
                default: begin
                    w_state_next = S_FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_FILL;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_wr_ptr    <= '0;
            r_mode      <= 1'b0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sum       <= w_sum_next;
            r_cnt       <= w_cnt_next;
            r_wr_ptr    <= w_wr_ptr_next;
            r_mode      <= mode;
            r_y         <= w_y_next;
            r_out_valid <= w_pulse;
        end
    end

    // Sample storage is never cleared; entries are always rewritten before they are read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wr_ptr] <= x;
        end
    end

    assign y         = r_y;
    assign out_valid = r_out_valid;
    assign win_full  = (r_state == S_STEADY);

endmodule

// File: tb/tb_moving_avg_filter.sv
// tb/tb_moving_avg_filter.sv - self-checking bench for moving_avg_filter against a queue-based model
module tb_moving_avg_filter;

    localparam int DW     = 16;
    localparam int LOG2_N = 3;
    localparam int N      = 1 << LOG2_N;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] x;
    logic          mode;
    logic          flush;
    logic [DW-1:0] y;
    logic          out_valid;
    logic          win_full;

    int checks = 0;
    int errors = 0;

    moving_avg_filter #(.DW(DW), .LOG2_N(LOG2_N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .x        (x),
        .mode     (mode),
        .flush    (flush),
        .y        (y),
        .out_valid(out_valid),
        .win_full (win_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the window is a plain queue of accepted samples; the mean is its sum divided by N.
    int   win[$];
    int   m_y;
    logic m_ov;
    logic m_full;
    logic m_mode;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            win.delete();
            m_y    = 0;
            m_ov   = 1'b0;
            m_full = 1'b0;
            m_mode = 1'b0;
        end else begin
            m_ov = 1'b0;
            if (flush || (mode != m_mode)) begin
                win.delete();
                m_full = 1'b0;
            end else if (in_valid) begin
                win.push_back(int'(x));
                if (!mode && win.size() > N) void'(win.pop_front());
                if (win.size() == N) begin
                    int s;
                    s = 0;
                    foreach (win[i]) s += win[i];
                    m_y  = s / N;
                    m_ov = 1'b1;
                    if (mode) win.delete();
                    else m_full = 1'b1;
                end
            end
            m_mode = mode;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    int got[$];

    always @(negedge clk) begin
        if (!rst) begin
            chk("y", int'(y), m_y);
            chk("out_valid", int'(out_valid), int'(m_ov));
            chk("win_full", int'(win_full), int'(m_full));
            if (out_valid) got.push_back(int'(y));
        end
    end

    task automatic check_list(input string name, input int exp[$]);
        chk({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk(name, got[i], exp[i]);
        got.delete();
    endtask

    task automatic send(input int v);
        @(negedge clk);
        in_valid = 1'b1;
        x        = DW'(v);
        flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            flush    = 1'b0;
        end
    endtask

    task automatic set_mode(input logic m);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        mode     = m;
    endtask

    task automatic do_flush();
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b1;
    endtask

    task automatic send_alt();
        for (int i = 0; i < N; i++) send((i % 2 == 0) ? 8 : 10);
    endtask

    task automatic send_rep(input int v, input int n);
        for (int i = 0; i < n; i++) send(v);
    endtask

    int e[$];

    initial begin
        rst = 1'b1; in_valid = 1'b0; x = '0; mode = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_y", int'(y), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_win_full", int'(win_full), 0);
        rst = 1'b0;
        got.delete();

        // Sliding mode, alternating then constant samples
        send_alt(); idle(2);
        e = '{9}; check_list("slide_first", e);
        send_rep(10, 8); idle(2);
        e = '{9, 9, 9, 9, 9, 9, 10, 10}; check_list("slide_steady", e);
        chk("slide_win_full", int'(win_full), 1);

        // Block mode
        set_mode(1'b1);
        send_alt(); send_rep(10, 8);
        send(15); send(30); send(45); send(15); send(30); send(45); send(10); send(10);
        idle(2);
        e = '{9, 10, 25}; check_list("block", e);
        chk("block_win_full", int'(win_full), 0);

        // Full-scale samples, then decay in sliding mode
        send_rep(16'hFFFF, 8); idle(2);
        e = '{16'hFFFF}; check_list("block_max", e);
        set_mode(1'b0);
        send_rep(16'hFFFF, 8); idle(2);
        e = '{16'hFFFF}; check_list("slide_max", e);
        send_rep(0, 8); idle(2);
        e = '{16'hDFFF, 16'hBFFF, 16'h9FFF, 16'h7FFF, 16'h5FFF, 16'h3FFF, 16'h1FFF, 16'h0000};
        check_list("slide_decay", e);

        // Gaps during fill
        do_flush();
        for (int i = 0; i < N; i++) begin
            send((i % 2 == 0) ? 8 : 10);
            idle(2);
        end
        idle(2);
        e = '{9}; check_list("gapped", e);

        // Flush and mode toggle mid-window
        do_flush();
        send_rep(100, 5); do_flush();
        send_rep(4, 8); idle(2);
        e = '{4}; check_list("flush_mid", e);
        do_flush();
        send_rep(100, 5); set_mode(1'b1); set_mode(1'b0);
        send_rep(4, 8); idle(2);
        e = '{4}; check_list("toggle_mid", e);

        // Asynchronous reset between edges while in steady state
        send_rep(50, 3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_y", int'(y), 0);
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_win_full", int'(win_full), 0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got.delete();
        send_alt(); idle(2);
        e = '{9}; check_list("rst_refill", e);
        send_rep(10, 8); idle(2);
        e = '{9, 9, 9, 9, 9, 9, 10, 10}; check_list("rst_steady", e);

        // Randomised traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       x = '0;
                1:       x = '1;
                default: x = DW'($urandom_range(0, 65535));
            endcase
            flush = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 99) == 0) mode = ~mode;
            if ((c % 700) == 350) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        idle(3);
        got.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/moving_avg_filter.md
# moving_avg_filter

- Parametrised streaming mean-value filter: accepts unsigned samples under a valid strobe and outputs the arithmetic mean of the last 2^LOG2_N accepted samples.
- Two run-time modes: sliding window (one result per sample once the window is full) and block/decimating (one result per N samples).
- Successor to the fixed 8-sample, 16-bit mean_value block; sits between the sample source and downstream datapath logic.

## Interface
- DW, 16, sample and result width (unsigned)
- LOG2_N, 3, log2 of window length; N = 2^LOG2_N, legal range 1..8
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  sample x accepted on a clk edge where in_valid=1
- x  in  DW  input sample
- mode  in  1  0 = sliding window, 1 = block (decimating)
- flush  in  1  synchronous clear of window state; has priority over in_valid
- y  out  DW  registered mean; holds its value between updates
- out_valid  out  1  one-cycle pulse when y has just updated
- win_full  out  1  window holds N valid samples (sliding mode) / reserved 0 in block mode

## Operation
- Storage: N-entry circular buffer of DW bits, write pointer wr_ptr (LOG2_N bits, wraps N-1 -> 0), fill counter cnt (0..N), accumulator sum of DW+LOG2_N bits. Overflow cannot occur at this width.
- Result: y = sum_next >> LOG2_N. Truncation, no rounding. Unsigned arithmetic only.
- State machine, shared by both modes:
  - FILL (cnt<N): on an accepted sample, buffer[wr_ptr]<=x, sum<=sum+x, cnt++, wr_ptr++.
  - Sliding mode, cnt reaching N: go to STEADY, pulse out_valid with the first mean.
  - Block mode, cnt reaching N: pulse out_valid, then clear sum and cnt to 0 and stay in FILL.
  - STEADY (sliding only): on an accepted sample, sum<=sum+x-buffer[wr_ptr], buffer[wr_ptr]<=x, wr_ptr++, out_valid pulses every accepted sample.
- The oldest sample is subtracted only in STEADY. Buffer contents are never cleared. Stale entries are never read before being overwritten.
- Mode change:
  - mode is sampled every cycle.
  - Any change of mode, detected against a registered copy, acts as a flush in that cycle. The sample offered in that cycle is discarded.
- flush = 1: sum, cnt, wr_ptr <= 0, state <= FILL, out_valid <= 0. y keeps its last value. in_valid in the same cycle is ignored.
- win_full = 1 exactly while in STEADY.

## Timing
- Reset values: y=0, out_valid=0, win_full=0, sum=0, cnt=0, wr_ptr=0, state=FILL, registered mode=0.
- Reset assertion mid-operation clears all state immediately (asynchronous). The first sample after release starts a fresh window.
- Latency: out_valid and the new y appear on the clk edge that accepts the producing sample. They are visible in the following cycle, i.e. 1-cycle registered latency.
- Sliding mode: first out_valid on the Nth accepted sample, then one per accepted sample.
- Block mode: one out_valid per N accepted samples.
- in_valid=0 cycles: no state change, out_valid=0. Gaps are transparent to the mean.
- Throughput: one sample per clock, with no back-pressure.

## Test plan
- Sliding mode, DW=16, LOG2_N=3, back-to-back samples 8,10,8,10,8,10,8,10 -> out_valid first pulses after the 8th sample with y=9. Then eight samples of 10 -> y=9,9,9,9,9,9,10,10, win_full=1 throughout.
- Block mode, same parameters, sequence 8,10,8,10,8,10,8,10 / 10×8 / 15,30,45,15,30,45,10,10 -> exactly three out_valid pulses with y=9, 10, 25. No pulses in between.
- Eight samples of 0xFFFF in both modes -> y=0xFFFF, no wrap. Then eight samples of 0 in sliding mode -> y decays 0xDFFF,0xBFFF,...,0x1FFF,0x0000.
- in_valid toggled 1,0,0,1,... during a fill -> result identical to back-to-back feed. out_valid never asserted in an in_valid=0 cycle.
- flush after 5 samples, then 8 samples of 4 -> first out_valid only after the 8th new sample with y=4. A mode toggle mid-window behaves the same.
- rst asserted asynchronously between clock edges mid-stream -> y, out_valid, win_full go to 0 immediately. Refill after release behaves as in the first scenario.
